// File: rtl/branch_pkg.sv
// Shared branch-resolution types: condition codes, 2-bit predictor states,
// and the helpers that evaluate a condition and step a counter.
package branch_pkg;

  typedef enum logic [2:0] {
    BR_NONE   = 3'd0,
    BR_EQ     = 3'd1,
    BR_NE     = 3'd2,
    BR_GE0    = 3'd3,
    BR_GT0    = 3'd4,
    BR_LE0    = 3'd5,
    BR_LT0    = 3'd6,
    BR_ALWAYS = 3'd7
  } br_cond_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic logic br_eval(input br_cond_e cond, input logic zero, input logic sign);
    logic taken;
    taken = 1'b0;
    unique case (cond)
      BR_NONE:   taken = 1'b0;
      BR_EQ:     taken = zero;
      BR_NE:     taken = !zero;
      BR_GE0:    taken = !sign;
      BR_GT0:    taken = !sign && !zero;
      BR_LE0:    taken = sign || zero;
      BR_LT0:    taken = sign;
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
    return taken;
  endfunction

  // Saturating step: ST and SNT absorb further moves in their own direction.
  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    ctr_e nxt;
    nxt = cur;
    unique case (cur)
      SNT:     nxt = taken ? WNT : SNT;
      WNT:     nxt = taken ? WT  : SNT;
      WT:      nxt = taken ? ST  : WNT;
      ST:      nxt = taken ? ST  : WT;
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch-lookup, EX-resolve and statistics signals of the branch resolve unit.
interface branch_resolve_unit_if #(
  parameter int unsigned PC_WIDTH = 32
);
  logic [PC_WIDTH-1:0] if_pc;
  logic                if_pred_taken;
  logic                ex_valid;
  logic [2:0]          ex_branch;
  logic                ex_zero;
  logic                ex_sign;
  logic [PC_WIDTH-1:0] ex_pc;
  logic [PC_WIDTH-1:0] ex_target;
  logic                ex_pred_taken;
  logic                br_taken;
  logic                mispredict;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic [31:0]         stat_branches;
  logic [31:0]         stat_mispredicts;

  modport master (
    output if_pc, ex_valid, ex_branch, ex_zero, ex_sign, ex_pc, ex_target, ex_pred_taken,
    input  if_pred_taken, br_taken, mispredict, redirect_pc, stat_branches, stat_mispredicts
  );

  modport slave (
    input  if_pc, ex_valid, ex_branch, ex_zero, ex_sign, ex_pc, ex_target, ex_pred_taken,
    output if_pred_taken, br_taken, mispredict, redirect_pc, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_resolve_unit_bht_table.sv
// Branch history table: 2-bit saturating counters, combinational read,
// synchronous single-entry update, async reset to weak-not-taken.
module bht_table
  import branch_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx_i,
  output ctr_e             rd_ctr_o,
  input  logic             upd_en_i,
  input  logic [IDX_W-1:0] upd_idx_i,
  input  logic             upd_taken_i
);

  ctr_e ctr_q [ENTRIES];
  ctr_e upd_d;

  // Read sees the pre-edge value, so a same-cycle update is not forwarded.
  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_comb begin
    upd_d = ctr_next(ctr_q[upd_idx_i], upd_taken_i);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= WNT;
      end
    end else if (upd_en_i) begin
      ctr_q[upd_idx_i] <= upd_d;
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: condition evaluation, BHT prediction/update, registered
// redirect outputs. Statistics counters exist only with BRANCH_RESOLVE_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int unsigned PC_WIDTH    = 32,
  parameter int unsigned BHT_ENTRIES = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(BHT_ENTRIES);

  logic [IDX_W-1:0]    if_idx;
  logic [IDX_W-1:0]    ex_idx;
  ctr_e                rd_ctr;
  logic                cond_taken;
  logic                resolve;
  logic                pc_unused;

  logic                live_q;
  logic                br_taken_q,    br_taken_d;
  logic                mispredict_q,  mispredict_d;
  logic [PC_WIDTH-1:0] redirect_q,    redirect_d;

  assign if_idx    = bus.if_pc[IDX_W+1:2];
  assign ex_idx    = bus.ex_pc[IDX_W+1:2];
  assign pc_unused = ^{bus.if_pc, bus.ex_pc};

  assign cond_taken = br_eval(br_cond_e'(bus.ex_branch), bus.ex_zero, bus.ex_sign);

  // live_q stays low through the first edge after reset release, so a
  // resolve presented across that edge is never applied.
  assign resolve = live_q && bus.ex_valid && (br_cond_e'(bus.ex_branch) != BR_NONE);

  bht_table #(
    .ENTRIES (BHT_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_bht (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_idx_i    (if_idx),
    .rd_ctr_o    (rd_ctr),
    .upd_en_i    (resolve),
    .upd_idx_i   (ex_idx),
    .upd_taken_i (cond_taken)
  );

  assign bus.if_pred_taken = rd_ctr[1];

  always_comb begin
    br_taken_d   = br_taken_q;
    redirect_d   = redirect_q;
    mispredict_d = 1'b0;
    if (resolve) begin
      br_taken_d   = cond_taken;
      redirect_d   = cond_taken ? bus.ex_target : (bus.ex_pc + PC_WIDTH'(4));
      mispredict_d = (cond_taken != bus.ex_pred_taken);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q       <= 1'b0;
      br_taken_q   <= 1'b0;
      mispredict_q <= 1'b0;
      redirect_q   <= '0;
    end else begin
      live_q       <= 1'b1;
      br_taken_q   <= br_taken_d;
      mispredict_q <= mispredict_d;
      redirect_q   <= redirect_d;
    end
  end

  assign bus.br_taken    = br_taken_q;
  assign bus.mispredict  = mispredict_q;
  assign bus.redirect_pc = redirect_q;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mp_q, stat_mp_d;

  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (resolve && (stat_br_q != '1)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (mispredict_d && (stat_mp_q != '1)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`else
  assign bus.stat_branches    = '0;
  assign bus.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus
// randomized resolves compared against a behavioural predictor model.
module tb_branch_resolve_unit;

  localparam int unsigned PCW = 32;
  localparam int unsigned NBHT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  branch_resolve_unit_if #(.PC_WIDTH(PCW)) bus_if ();

  branch_resolve_unit #(
    .PC_WIDTH    (PCW),
    .BHT_ENTRIES (NBHT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  // Behavioural model state
  int unsigned mctr [NBHT];
  bit          exp_bt;
  bit          exp_mp;
  logic [31:0] exp_rd;
  int unsigned exp_sb;
  int unsigned exp_sm;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cond_of(input int code, input bit z, input bit s);
    case (code)
      1:       return z;
      2:       return !z;
      3:       return !s;
      4:       return !s && !z;
      5:       return s || z;
      6:       return s;
      7:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return (pc / 4) % NBHT;
  endfunction

  task automatic drive(input bit v, input int code, input bit z, input bit s,
                       input logic [31:0] pc, input logic [31:0] tgt, input bit pred,
                       input logic [31:0] ifpc);
    bus_if.ex_valid      = v;
    bus_if.ex_branch     = 3'(code);
    bus_if.ex_zero       = z;
    bus_if.ex_sign       = s;
    bus_if.ex_pc         = pc;
    bus_if.ex_target     = tgt;
    bus_if.ex_pred_taken = pred;
    bus_if.if_pc         = ifpc;
  endtask

  task automatic drive_idle(input logic [31:0] ifpc);
    drive(1'b0, 0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ifpc);
  endtask

  task automatic check_outputs();
    check_val("br_taken",   bus_if.br_taken,         exp_bt);
    check_val("mispredict", bus_if.mispredict,       exp_mp);
    check_val("redirect",   bus_if.redirect_pc,      exp_rd);
    check_val("stat_br",    bus_if.stat_branches,    exp_sb);
    check_val("stat_mp",    bus_if.stat_mispredicts, exp_sm);
  endtask

  task automatic check_table();
    for (int i = 0; i < int'(NBHT); i++) begin
      check_val($sformatf("bht[%0d]", i), dut.u_bht.ctr_q[i], mctr[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(NBHT); i++) mctr[i] = 1;
    exp_bt = 1'b0;
    exp_mp = 1'b0;
    exp_rd = '0;
    exp_sb = 0;
    exp_sm = 0;
  endtask

  // Called at a negedge with inputs already driven; ends at the next negedge.
  task automatic run_cycle();
    bit c;
    bit res;
    int unsigned ix;
    #1;
    check_val("if_pred", bus_if.if_pred_taken, mctr[idx_of(bus_if.if_pc)] >= 2);
    res = bus_if.ex_valid && (bus_if.ex_branch != 3'd0);
    c   = cond_of(int'(bus_if.ex_branch), bus_if.ex_zero, bus_if.ex_sign);
    @(posedge clk);
    exp_mp = res && (c != bus_if.ex_pred_taken);
    if (res) begin
      exp_bt = c;
      exp_rd = c ? bus_if.ex_target : bus_if.ex_pc + 32'd4;
      ix = idx_of(bus_if.ex_pc);
      if (c && mctr[ix] < 3) mctr[ix]++;
      else if (!c && mctr[ix] > 0) mctr[ix]--;
`ifdef BRANCH_RESOLVE_STATS_EN
      exp_sb++;
      if (exp_mp) exp_sm++;
`endif
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    drive_idle(32'h40);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle();
  endtask

  initial begin
    drive_idle(32'h40);
    model_reset();

    // Reset state
    #1;
    check_outputs();
    check_val("rst_if_pred", bus_if.if_pred_taken, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_cycle();
    check_table();

    // Taken eq-branch with NT prediction
    drive(1'b1, 1, 1'b1, 1'b0, 32'h40, 32'h80, 1'b0, 32'h40);
    run_cycle();
    check_val("d34_bt",  bus_if.br_taken, 1'b1);
    check_val("d34_mp",  bus_if.mispredict, 1'b1);
    check_val("d34_rd",  bus_if.redirect_pc, 32'h80);
    check_val("d34_ctr", dut.u_bht.ctr_q[0], 2'b10);
    drive_idle(32'h40);
    run_cycle();
    check_val("d34_mp_clr", bus_if.mispredict, 1'b0);
    check_val("d34_rd_hold", bus_if.redirect_pc, 32'h80);

    // Saturation up then two steps down
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 7, 1'b0, 1'b0, 32'h40, 32'h200, 1'b1, 32'h40);
      run_cycle();
    end
    check_val("d35_sat", dut.u_bht.ctr_q[0], 2'b11);
    check_val("d35_p0",  bus_if.if_pred_taken, 1'b1);
    drive(1'b1, 1, 1'b0, 1'b0, 32'h40, 32'h200, 1'b1, 32'h40);
    run_cycle();
    check_val("d35_p1", bus_if.if_pred_taken, 1'b1);
    drive(1'b1, 1, 1'b0, 1'b0, 32'h40, 32'h200, 1'b1, 32'h40);
    run_cycle();
    check_val("d35_p2",  bus_if.if_pred_taken, 1'b0);
    check_val("d35_ctr", dut.u_bht.ctr_q[0], 2'b01);

    // gt0 with zero set is not taken; unconditional with pred=1 is correct
    drive(1'b1, 4, 1'b1, 1'b0, 32'h1000, 32'h2000, 1'b1, 32'h40);
    run_cycle();
    check_val("d36_bt", bus_if.br_taken, 1'b0);
    check_val("d36_mp", bus_if.mispredict, 1'b1);
    check_val("d36_rd", bus_if.redirect_pc, 32'h1004);
    drive(1'b1, 7, 1'b0, 1'b0, 32'h1000, 32'h2000, 1'b1, 32'h40);
    run_cycle();
    check_val("d36_mp7", bus_if.mispredict, 1'b0);

    // Read-before-write on the same entry
    apply_reset();
    drive(1'b1, 7, 1'b0, 1'b0, 32'h44, 32'h300, 1'b0, 32'h44);
    #1;
    check_val("d37_pre", bus_if.if_pred_taken, 1'b0);
    run_cycle();
    check_val("d37_post", bus_if.if_pred_taken, 1'b1);

    // Reset pulse during a mispredicting resolve, released on a clock edge
    apply_reset();
    drive(1'b1, 7, 1'b0, 1'b0, 32'h40, 32'h400, 1'b1, 32'h40);
    run_cycle();
    run_cycle();
    drive(1'b1, 7, 1'b0, 1'b0, 32'h40, 32'h400, 1'b0, 32'h40);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("d38_mp_async", bus_if.mispredict, 1'b0);
    check_outputs();
    @(posedge clk);
    #1;
    check_val("d38_mp_hold", bus_if.mispredict, 1'b0);
    check_table();
    @(negedge clk);
    @(posedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("d38_mp_rel", bus_if.mispredict, 1'b0);
    check_outputs();
    check_table();
    drive_idle(32'h40);
    run_cycle();

    // Statistics: three resolves, two of them mispredicted
    drive(1'b1, 7, 1'b0, 1'b0, 32'h40, 32'h500, 1'b0, 32'h40);
    run_cycle();
    drive(1'b1, 1, 1'b1, 1'b0, 32'h48, 32'h600, 1'b1, 32'h40);
    run_cycle();
    drive(1'b1, 2, 1'b1, 1'b0, 32'h4C, 32'h700, 1'b1, 32'h40);
    run_cycle();
`ifdef BRANCH_RESOLVE_STATS_EN
    check_val("d38_sb", bus_if.stat_branches, 32'd3);
    check_val("d38_sm", bus_if.stat_mispredicts, 32'd2);
`else
    check_val("d38_sb", bus_if.stat_branches, 32'd0);
    check_val("d38_sm", bus_if.stat_mispredicts, 32'd0);
`endif

    // Randomized resolves on a small PC pool to force aliasing and saturation
    for (int n = 0; n < 400; n++) begin
      logic [31:0] pc;
      logic [31:0] ifpc;
      logic [31:0] tgt;
      pc   = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      if ($urandom_range(0, 9) == 0) pc = $urandom;
      ifpc = ($urandom_range(0, 3) == 0) ? pc : 32'h100 + 32'($urandom_range(0, 15)) * 4;
      tgt  = $urandom & 32'hFFFF_FFFC;
      if (n == 200) pc = 32'hFFFF_FFFC;
      drive($urandom_range(0, 4) != 0, int'($urandom_range(0, 7)), 1'($urandom),
            1'($urandom), pc, tgt, 1'($urandom), ifpc);
      run_cycle();
    end
    check_table();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 32, meaning the width of the program counter and target.
REQ-002 SHALL have parameter BHT_ENTRIES, default 16, meaning the number of predictor entries; power of two, minimum 2; IDX_W = log2(BHT_ENTRIES).
REQ-003 SHALL have port clk, input, 1, the single clock; all flops rising-edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port if_pc, input, PC_WIDTH, the fetch PC used for prediction lookup.
REQ-006 SHALL have port if_pred_taken, output, 1, the combinational prediction for if_pc.
REQ-007 SHALL have port ex_valid, input, 1, qualifying the EX-stage branch resolution for this cycle.
REQ-008 SHALL have port ex_branch, input, 3, the condition code.
REQ-009 SHALL have ports ex_zero and ex_sign, input, 1 each, the ALU flags.
REQ-010 SHALL have ports ex_pc and ex_target, input, PC_WIDTH each, the branch PC and taken target.
REQ-011 SHALL have port ex_pred_taken, input, 1, the prediction carried down the pipe with the branch.
REQ-012 SHALL have port br_taken, output, 1, the registered resolved direction.
REQ-013 SHALL have port mispredict, output, 1, a registered one-cycle flush pulse.
REQ-014 SHALL have port redirect_pc, output, PC_WIDTH, the registered correct next PC, valid when mispredict=1.
REQ-015 SHALL have ports stat_branches and stat_mispredicts, output, 32 each, the statistics counters.

Function
REQ-016 Condition codes SHALL be: 0 none (not taken); 1 eq (zero); 2 ne (!zero); 3 ge0 (!sign); 4 gt0 (!sign && !zero); 5 le0 (sign || zero); 6 lt0 (sign); 7 unconditional (always taken).
REQ-017 Predictor SHALL be BHT_ENTRIES 2-bit saturating counters indexed by pc[IDX_W+1:2]; encoding 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-018 if_pred_taken SHALL be the MSB of the entry indexed by if_pc, with zero latency.
REQ-019 A resolve event SHALL be ex_valid=1 with ex_branch!=0; ex_valid=0 or ex_branch=0 SHALL leave all state unchanged except that mispredict is deasserted next cycle.
REQ-020 On a resolve event, br_taken SHALL take the condition result at the next rising edge, i.e. 1-cycle latency.
REQ-021 On a resolve event, mispredict SHALL be asserted for exactly one cycle after the edge when the condition result differs from ex_pred_taken.
REQ-022 redirect_pc SHALL be ex_target when taken and ex_pc+4 (modulo 2^PC_WIDTH) when not taken; it SHALL hold its value when no resolve event occurs.
REQ-023 On a resolve event, the indexed counter SHALL increment when taken and decrement when not taken, saturating at 11 and 00 with no wrap.
REQ-024 When if_pc and ex_pc index the same entry in the same cycle, if_pred_taken SHALL return the pre-update value (read-before-write).
REQ-025 Back-to-back resolve events on consecutive cycles SHALL each update the table and each produce their own mispredict result.

Reset
REQ-026 Asserting rst_n low SHALL immediately force br_taken=0, mispredict=0, redirect_pc=0, statistics=0, and every counter=01, including when asserted mid-resolve.
REQ-027 No resolve event SHALL be applied on the rising edge coincident with rst_n deassertion if rst_n was low before that edge.

Configuration
REQ-028 Macro BRANCH_RESOLVE_STATS_EN SHALL control the statistics counters.
REQ-029 With BRANCH_RESOLVE_STATS_EN defined, stat_branches SHALL count resolve events and stat_mispredicts SHALL count mispredicts, both saturating at 32'hFFFF_FFFF.
REQ-030 Without BRANCH_RESOLVE_STATS_EN, the statistics ports SHALL remain present, tied to 0, with no flops inferred.

Structure
REQ-031 Shared package branch_pkg SHALL hold the condition-code constants (BR_NONE..BR_ALWAYS) and the counter-state constants (SNT, WNT, WT, ST).
REQ-032 Sub-module bht_table SHALL contain the counter array, one combinational read port, one synchronous update port, and async reset to WNT; condition evaluation, output registers and statistics logic SHALL reside in the top module.

Verification
REQ-033 Reset, then if_pc=0x40 -> if_pred_taken=0; all outputs 0; stats 0.
REQ-034 Branch code 1 with zero=1, pc=0x40, target=0x80, pred=0 -> next cycle br_taken=1, mispredict=1 for one cycle, redirect_pc=0x80, entry 0 goes from 01 to 10.
REQ-035 Four taken resolves at pc=0x40, then two not-taken resolves -> counter 11 saturates at 11, then steps to 10 and 01; if_pred_taken reads 1, then 1, then 0.
REQ-036 Branch code 4 with sign=0, zero=1, pc=0x1000, pred=1 -> br_taken=0, mispredict=1, redirect_pc=0x1004; branch code 7 with pred=1 -> mispredict=0.
REQ-037 With if_pc=ex_pc=0x44, entry 01, and a taken resolve -> if_pred_taken=0 in that cycle and 1 in the next cycle.
REQ-038 rst_n pulsed low during a mispredicting resolve -> mispredict never asserted and the table returns to 01; with BRANCH_RESOLVE_STATS_EN, 3 resolves including 2 mispredicts give stats 3/2.
